i2s_tx: RTL and testbench
=========================

// Module: i2s_tx
// PURPOSE
//  I2S transmitter, the playback counterpart of the microphone receiver. HPS writes 24-bit
//  left/right sample pairs over an Avalon-MM slave into a sample FIFO; block generates
//  SCK/WS from clk and shifts samples out MSB-first on SD. Level irq requests refills.
// PARAMETERS
//  CLK_DIV     8   clk cycles per SCK half-period (50 MHz / 16 = 3.125 MHz SCK, ~48.8 kHz fs)
//  SAMPLE_W    24  bits per channel sample
//  FIFO_DEPTH  8   sample pairs held; power of 2, >= 2
// PORTS
//  clk         in   1   system clock, 50 MHz; only clock
//  reset       in   1   synchronous, active-high
//  chipselect  in   1   Avalon-MM select
//  write       in   1   Avalon-MM write strobe
//  read        in   1   Avalon-MM read strobe
//  address     in   3   register index
//  writedata   in   32  write data
//  readdata    out  32  read data, registered
//  irq         out  1   level interrupt
//  SCK         out  1   I2S bit clock
//  WS          out  1   word select: 0 = left slot, 1 = right slot
//  SD          out  1   serial data
// BEHAVIOUR
//  Reset: SCK=WS=SD=0, irq=0, readdata=0, FIFO empty, ctrl=0, sticky flags 0, counters 0.
//  Registers (write): 0 LEFT stage[23:0]; 1 RIGHT: pushes {LEFT stage, writedata[23:0]};
//   3 CTRL: [0] enable, [1] irq_en; 4 CLEAR: writedata[0] clears underrun, [1] clears overflow.
//  Registers (read, readdata valid cycle after read&chipselect): 2 STATUS = {fill[7:0] at
//   [15:8], overflow[3], underrun[2], full[1], empty[0]}; 3 CTRL; other addresses return 0.
//  Push to full FIFO: dropped, overflow<=1. Push and pop same cycle: both happen, fill unchanged.
//  SCK gen: div_cnt 0..CLK_DIV-1; at terminal count SCK toggles. Falling-edge event = toggle
//   with SCK=1. All WS/SD/bit_cnt updates occur only on falling-edge events.
//  Frame: bit_cnt 6 bits, 0..63, wraps. WS = bit_cnt[5]. Slot bit b = bit_cnt[4:0]:
//   b=1..24 drive sample[24-b] (MSB at b=1, one SCK after WS edge); b=0, 25..31 drive 0.
//  Load: on event entering bit_cnt=0, pop one pair into left/right shift regs. FIFO empty
//   then: load zeros, underrun<=1, no pop. Right reg shifts only in right slot.
//  enable=0: div_cnt, bit_cnt cleared, SCK/WS/SD held 0, no pops; FIFO kept and writable.
//   Clearing enable mid-frame aborts frame next clk; set again starts at bit_cnt=0 with a pop
//   on first falling-edge event (SCK first rises after CLK_DIV clks).
//  irq = irq_en & (fill <= FIFO_DEPTH/2 | underrun), registered (1 clk latency).
//  reset mid-frame: full return to reset values; FIFO contents discarded.
// CONFIGURATION
//  I2S_TX_MONO_EN defined: address 5 write pushes {writedata[23:0], writedata[23:0]} (same
//   sample both channels), CTRL[2] read-only 1. Undefined: address 5 ignored, CTRL[2] reads 0.
// STRUCTURE
//  i2s_pkg: SAMPLE_W, FRAME_BITS=64, SLOT_BITS=32, register address localparams, status bit
//   positions, sample_pair_t struct {left, right}. Shared with the receiver.
//  Sub-module i2s_tx_fifo: synchronous FIFO of sample_pair_t, push/pop/full/empty/fill.
// TESTING
//  Push L=0xA5A5A5,R=0x5A5A5A, enable=1 -> SD over bits 1..24 of each slot matches MSB-first,
//   bits 0,25..31 zero, WS 32 SCK low then 32 high, SCK period 320 ns.
//  enable=1 with FIFO empty -> SD all zero, STATUS.underrun=1; irq=1 once irq_en=1; CLEAR
//   bit0 with FIFO refilled above 4 -> irq=0.
//  Push 9 pairs, enable=0 -> STATUS full=1, fill=8, overflow=1; 9th pair never transmitted.
//  Fill 8 pairs, run -> irq rises when fill reaches 4; pairs emerge in write order.
//  Drop enable at bit_cnt=40 -> SCK/WS/SD 0 next clk; re-enable -> next frame starts at
//   left slot with next FIFO pair.
//  I2S_TX_MONO_EN build: address 5 write 0x123456 -> both slots carry 0x123456.

Source files
------------

// File: rtl/i2s_pkg.sv
// Shared I2S definitions: frame geometry, register map, status bit positions
// and the left/right sample pair carried by transmitter and receiver.
package i2s_pkg;

    localparam int SAMPLE_W   = 24;
    localparam int FRAME_BITS = 64;
    localparam int SLOT_BITS  = 32;

    localparam logic [2:0] ADDR_LEFT   = 3'd0;
    localparam logic [2:0] ADDR_RIGHT  = 3'd1;
    localparam logic [2:0] ADDR_STATUS = 3'd2;
    localparam logic [2:0] ADDR_CTRL   = 3'd3;
    localparam logic [2:0] ADDR_CLEAR  = 3'd4;
    localparam logic [2:0] ADDR_MONO   = 3'd5;

    localparam int ST_EMPTY    = 0;
    localparam int ST_FULL     = 1;
    localparam int ST_UNDERRUN = 2;
    localparam int ST_OVERFLOW = 3;
    localparam int ST_FILL_LSB = 8;

    typedef struct packed {
        logic [SAMPLE_W-1:0] left;
        logic [SAMPLE_W-1:0] right;
    } sample_pair_t;

endpackage

// File: rtl/i2s_tx_fifo.sv
// Synchronous FIFO of sample pairs. A push while full is dropped even if a pop
// happens in the same cycle; the caller records the overflow.
module i2s_tx_fifo
    import i2s_pkg::*;
#(
    parameter int DEPTH = 8
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     push_i,
    input  sample_pair_t             data_i,
    input  logic                     pop_i,
    output sample_pair_t             data_o,
    output logic                     full_o,
    output logic                     empty_o,
    output logic [$clog2(DEPTH):0]   fill_o
);

    localparam int AW = $clog2(DEPTH);

    sample_pair_t   mem_q [DEPTH];
    logic [AW-1:0]  wr_ptr_q, rd_ptr_q;
    logic [AW:0]    fill_q;
    logic           push_ok, pop_ok;

    assign full_o  = (fill_q == (AW+1)'(DEPTH));
    assign empty_o = (fill_q == '0);
    assign fill_o  = fill_q;
    assign data_o  = mem_q[rd_ptr_q];
    assign push_ok = push_i & ~full_o;
    assign pop_ok  = pop_i & ~empty_o;

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            fill_q   <= '0;
        end else begin
            if (push_ok) wr_ptr_q <= wr_ptr_q + AW'(1);
            if (pop_ok)  rd_ptr_q <= rd_ptr_q + AW'(1);
            if (push_ok && !pop_ok)      fill_q <= fill_q + (AW+1)'(1);
            else if (pop_ok && !push_ok) fill_q <= fill_q - (AW+1)'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (push_ok) mem_q[wr_ptr_q] <= data_i;
    end

endmodule

// File: rtl/i2s_tx.sv
// I2S transmitter: Avalon-MM sample FIFO feeding an SCK/WS/SD serializer.
// Build option I2S_TX_MONO_EN adds the address-5 mono push and CTRL[2] readback.
module i2s_tx
    import i2s_pkg::*;
#(
    parameter int CLK_DIV    = 8,
    parameter int FIFO_DEPTH = 8
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        chipselect,
    input  logic        write,
    input  logic        read,
    input  logic [2:0]  address,
    input  logic [31:0] writedata,
    output logic [31:0] readdata,
    output logic        irq,
    output logic        SCK,
    output logic        WS,
    output logic        SD
);

    localparam int FILL_W = $clog2(FIFO_DEPTH) + 1;
    localparam int DIV_W  = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [FILL_W-1:0] HALF_FILL = FILL_W'(FIFO_DEPTH / 2);
`ifdef I2S_TX_MONO_EN
    localparam logic MONO = 1'b1;
`else
    localparam logic MONO = 1'b0;
`endif

    logic                wr_en, rd_en;
    logic                push, pop, load;
    sample_pair_t        push_data, fifo_data;
    logic                fifo_full, fifo_empty;
    logic [FILL_W-1:0]   fifo_fill;

    logic [SAMPLE_W-1:0] left_stage_q;
    logic                enable_q, irq_en_q, underrun_q, overflow_q, irq_q, irq_d;
    logic [31:0]         readdata_q, readdata_d, status;

    logic [DIV_W-1:0]    div_cnt_q, div_cnt_d;
    logic                sck_q, sck_d, ws_q, ws_d, sd_q, sd_d, first_q, first_d;
    logic [5:0]          bit_cnt_q, bit_cnt_d, bit_nxt;
    logic [4:0]          slot_bit;
    logic [SAMPLE_W-1:0] left_sr_q, left_sr_d, right_sr_q, right_sr_d;
    logic                tick, fall_evt;
    logic                unused_wdata;

    assign wr_en        = chipselect & write;
    assign rd_en        = chipselect & read;
    assign unused_wdata = ^writedata[31:SAMPLE_W];

    always_comb begin
        push           = wr_en && (address == ADDR_RIGHT);
        push_data.left  = left_stage_q;
        push_data.right = writedata[SAMPLE_W-1:0];
`ifdef I2S_TX_MONO_EN
        if (wr_en && address == ADDR_MONO) begin
            push            = 1'b1;
            push_data.left  = writedata[SAMPLE_W-1:0];
            push_data.right = writedata[SAMPLE_W-1:0];
        end
`endif
    end

    i2s_tx_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
        .clk     (clk),
        .reset   (reset),
        .push_i  (push),
        .data_i  (push_data),
        .pop_i   (pop),
        .data_o  (fifo_data),
        .full_o  (fifo_full),
        .empty_o (fifo_empty),
        .fill_o  (fifo_fill)
    );

    // The very first falling edge after enable lands on bit 0 instead of advancing.
    assign tick     = (div_cnt_q == DIV_W'(CLK_DIV - 1));
    assign fall_evt = enable_q & tick & sck_q;
    assign bit_nxt  = first_q ? 6'd0 : bit_cnt_q + 6'd1;
    assign slot_bit = bit_nxt[4:0];
    assign pop      = load & ~fifo_empty;

    always_comb begin
        div_cnt_d  = div_cnt_q;
        sck_d      = sck_q;
        ws_d       = ws_q;
        sd_d       = sd_q;
        bit_cnt_d  = bit_cnt_q;
        first_d    = first_q;
        left_sr_d  = left_sr_q;
        right_sr_d = right_sr_q;
        load       = 1'b0;
        if (!enable_q) begin
            div_cnt_d = '0;
            sck_d     = 1'b0;
            ws_d      = 1'b0;
            sd_d      = 1'b0;
            bit_cnt_d = '0;
            first_d   = 1'b1;
        end else begin
            div_cnt_d = tick ? '0 : div_cnt_q + DIV_W'(1);
            if (tick) sck_d = ~sck_q;
            if (fall_evt) begin
                bit_cnt_d = bit_nxt;
                first_d   = 1'b0;
                ws_d      = bit_nxt[5];
                sd_d      = 1'b0;
                if (bit_nxt == 6'd0) begin
                    load       = 1'b1;
                    left_sr_d  = fifo_empty ? '0 : fifo_data.left;
                    right_sr_d = fifo_empty ? '0 : fifo_data.right;
                end else if (slot_bit >= 5'd1 && slot_bit <= 5'(SAMPLE_W)) begin
                    if (!bit_nxt[5]) begin
                        sd_d      = left_sr_q[SAMPLE_W-1];
                        left_sr_d = {left_sr_q[SAMPLE_W-2:0], 1'b0};
                    end else begin
                        sd_d       = right_sr_q[SAMPLE_W-1];
                        right_sr_d = {right_sr_q[SAMPLE_W-2:0], 1'b0};
                    end
                end
            end
        end
    end

    always_comb begin
        status                         = '0;
        status[ST_FILL_LSB +: 8]       = 8'(fifo_fill);
        status[ST_OVERFLOW]            = overflow_q;
        status[ST_UNDERRUN]            = underrun_q;
        status[ST_FULL]                = fifo_full;
        status[ST_EMPTY]               = fifo_empty;
        case (address)
            ADDR_STATUS: readdata_d = status;
            ADDR_CTRL:   readdata_d = {29'b0, MONO, irq_en_q, enable_q};
            default:     readdata_d = '0;
        endcase
        irq_d = irq_en_q & ((fifo_fill <= HALF_FILL) | underrun_q);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            enable_q   <= 1'b0;
            irq_en_q   <= 1'b0;
            underrun_q <= 1'b0;
            overflow_q <= 1'b0;
            irq_q      <= 1'b0;
            readdata_q <= '0;
            div_cnt_q  <= '0;
            sck_q      <= 1'b0;
            ws_q       <= 1'b0;
            sd_q       <= 1'b0;
            bit_cnt_q  <= '0;
            first_q    <= 1'b1;
        end else begin
            if (wr_en && address == ADDR_CTRL) begin
                enable_q <= writedata[0];
                irq_en_q <= writedata[1];
            end
            // A new event in the same cycle as a clear wins, so no flag is lost.
            if (wr_en && address == ADDR_CLEAR && writedata[0]) underrun_q <= 1'b0;
            if (wr_en && address == ADDR_CLEAR && writedata[1]) overflow_q <= 1'b0;
            if (load && fifo_empty) underrun_q <= 1'b1;
            if (push && fifo_full)  overflow_q <= 1'b1;
            irq_q <= irq_d;
            if (rd_en) readdata_q <= readdata_d;
            div_cnt_q <= div_cnt_d;
            sck_q     <= sck_d;
            ws_q      <= ws_d;
            sd_q      <= sd_d;
            bit_cnt_q <= bit_cnt_d;
            first_q   <= first_d;
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en && address == ADDR_LEFT) left_stage_q <= writedata[SAMPLE_W-1:0];
        left_sr_q  <= left_sr_d;
        right_sr_q <= right_sr_d;
    end

    assign readdata = readdata_q;
    assign irq      = irq_q;
    assign SCK      = sck_q;
    assign WS       = ws_q;
    assign SD       = sd_q;

endmodule

// File: tb/tb_i2s_tx.sv
// Scoreboard bench for i2s_tx: stimulus queues expected frames, reads and pin
// states; one monitor process captures SD/WS per SCK rise and compares.
`timescale 1ns/1ps
module tb_i2s_tx;

    logic        clk = 1'b0;
    logic        reset, chipselect, write, read;
    logic [2:0]  address;
    logic [31:0] writedata, readdata;
    logic        irq, SCK, WS, SD;

    i2s_tx #(.CLK_DIV(8), .FIFO_DEPTH(8)) dut (
        .clk        (clk),
        .reset      (reset),
        .chipselect (chipselect),
        .write      (write),
        .read       (read),
        .address    (address),
        .writedata  (writedata),
        .readdata   (readdata),
        .irq        (irq),
        .SCK        (SCK),
        .WS         (WS),
        .SD         (SD)
    );

    always #10 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;
    int frames_done = 0;
    int mon_idx = -1;
    int arm_cnt = 0;
    logic rd_seen = 1'b0;

    logic [63:0] frame_q[$];
    logic [31:0] rd_q[$];
    string       rd_nm_q[$];
    logic [3:0]  pin_q[$];
    string       pin_nm_q[$];
    logic [63:0] gen_act_q[$], gen_exp_q[$];
    string       gen_nm_q[$];
    string       to_q[$];

    always @(posedge clk) rd_seen <= chipselect & read;

    function automatic logic [63:0] exp_sd(input logic [47:0] pr);
        logic [63:0] v;
        logic [23:0] s;
        int b;
        v = '0;
        for (int i = 0; i < 64; i++) begin
            s = (i < 32) ? pr[47:24] : pr[23:0];
            b = i % 32;
            if (b >= 1 && b <= 24) v[63 - i] = s[24 - b];
        end
        return v;
    endfunction

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, required 0x%0h", nm, act, exp);
        end
    endtask

    initial begin : monitor
        logic [63:0] sd_buf, ws_buf, exp_v;
        logic        sck_prev;
        int          rises, arm_seen;
        time         prev_rise;
        string       nm;
        sd_buf = '0; ws_buf = '0; sck_prev = 1'b0;
        rises = 0; arm_seen = 0; prev_rise = 0;
        forever begin
            @(negedge clk);
            if (rd_seen && rd_q.size() > 0) begin
                nm = rd_nm_q.pop_front();
                check(nm, {32'b0, readdata}, {32'b0, rd_q.pop_front()});
            end
            while (pin_q.size() > 0) begin
                nm = pin_nm_q.pop_front();
                check(nm, {60'b0, SCK, WS, SD, irq}, {60'b0, pin_q.pop_front()});
            end
            while (gen_act_q.size() > 0) begin
                nm = gen_nm_q.pop_front();
                check(nm, gen_act_q.pop_front(), gen_exp_q.pop_front());
            end
            while (to_q.size() > 0) begin
                n_tests++;
                n_fail++;
                $display("FAIL %s: timed out, required event never seen", to_q.pop_front());
            end
            if (arm_seen != arm_cnt) begin
                arm_seen = arm_cnt;
                rises    = 0;
                mon_idx  = -1;
            end
            if (SCK && !sck_prev) begin
                rises++;
                if (rises >= 2) begin
                    mon_idx = (rises - 2) % 64;
                    sd_buf[63 - mon_idx] = SD;
                    ws_buf[63 - mon_idx] = WS;
                    if (mon_idx == 63 && frame_q.size() > 0) begin
                        exp_v = frame_q.pop_front();
                        check($sformatf("frame%0d_sd", frames_done), sd_buf, exp_v);
                        check("frame_ws", ws_buf, 64'h0000_0000_FFFF_FFFF);
                        check("sck_period_ns", 64'($time - prev_rise), 64'd320);
                        frames_done++;
                    end
                end
                prev_rise = $time;
            end
            sck_prev = SCK;
        end
    end

    task automatic wr(input logic [2:0] a, input logic [31:0] d);
        @(negedge clk);
        chipselect = 1'b1; write = 1'b1; address = a; writedata = d;
        @(negedge clk);
        chipselect = 1'b0; write = 1'b0;
    endtask

    task automatic rd(input logic [2:0] a, input logic [31:0] e, input string nm);
        @(negedge clk);
        chipselect = 1'b1; read = 1'b1; address = a;
        rd_q.push_back(e);
        rd_nm_q.push_back(nm);
        @(negedge clk);
        chipselect = 1'b0; read = 1'b0;
    endtask

    task automatic push_pair(input logic [47:0] p);
        wr(3'd0, {8'hEE, p[47:24]});
        wr(3'd1, {8'hEE, p[23:0]});
    endtask

    task automatic enable(input logic [31:0] ctrl);
        arm_cnt++;
        wr(3'd3, ctrl);
    endtask

    task automatic expect_pins(input string nm, input logic [3:0] e);
        @(posedge clk);
        #1;
        pin_q.push_back(e);
        pin_nm_q.push_back(nm);
    endtask

    task automatic gen(input string nm, input logic [63:0] act, input logic [63:0] e);
        gen_act_q.push_back(act);
        gen_exp_q.push_back(e);
        gen_nm_q.push_back(nm);
    endtask

    task automatic wait_frames(input int target, input int budget, input string nm);
        int n;
        n = 0;
        while (frames_done < target && n < budget) begin
            @(negedge clk);
            n++;
        end
        if (frames_done < target) to_q.push_back(nm);
    endtask

    logic [47:0] pv [8] = '{48'h000001_800000, 48'h123456_654321, 48'hFFFFFF_000000,
                            48'h7FFFFF_800001, 48'hABCDEF_FEDCBA, 48'h0F0F0F_F0F0F0,
                            48'h555555_AAAAAA, 48'h800000_000001};

    initial begin : watchdog
        #2ms;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin : stim
        int base, n;
        reset = 1'b1; chipselect = 1'b0; write = 1'b0; read = 1'b0;
        address = '0; writedata = '0;
        repeat (3) @(negedge clk);
        expect_pins("reset_pins", 4'b0000);
        @(negedge clk);
        gen("readdata_reset", {32'b0, readdata}, 64'd0);
        reset = 1'b0;
        rd(3'd2, 32'h0000_0001, "status_reset");
        rd(3'd3, 32'h0000_0000, "ctrl_reset");

        // Single known pair, hand-computed serial image
        push_pair(48'hA5A5A5_5A5A5A);
        rd(3'd2, 32'h0000_0100, "status_one_pair");
        frame_q.push_back(64'h52D2D280_2D2D2D00);
        base = frames_done;
        enable(32'd1);
        wait_frames(base + 1, 1500, "frame_a5");
        wr(3'd3, 32'd0);
        wr(3'd4, 32'd3);
        expect_pins("idle_after_disable", 4'b0000);

        // Underrun with empty FIFO
        frame_q.push_back(64'd0);
        base = frames_done;
        enable(32'd1);
        wait_frames(base + 1, 1500, "frame_underrun");
        rd(3'd2, 32'h0000_0005, "status_underrun");
        gen("irq_disabled", {63'b0, irq}, 64'd0);
        wr(3'd3, 32'd3);
        repeat (2) @(negedge clk);
        gen("irq_underrun", {63'b0, irq}, 64'd1);
`ifdef I2S_TX_MONO_EN
        rd(3'd3, 32'h0000_0007, "ctrl_readback");
`else
        rd(3'd3, 32'h0000_0003, "ctrl_readback");
`endif
        wr(3'd3, 32'd2);
        for (int k = 0; k < 5; k++) push_pair(pv[k]);
        repeat (2) @(negedge clk);
        gen("irq_sticky_underrun", {63'b0, irq}, 64'd1);
        wr(3'd4, 32'd1);
        repeat (2) @(negedge clk);
        gen("irq_cleared", {63'b0, irq}, 64'd0);
        rd(3'd2, 32'h0000_0500, "status_fill5");

        // Fill to full, overflow, then drain in order
        for (int k = 5; k < 8; k++) push_pair(pv[k]);
        rd(3'd2, 32'h0000_0802, "status_full");
        push_pair(48'hDEAD00_BEEF00);
        rd(3'd2, 32'h0000_080A, "status_overflow");
        wr(3'd5, 32'h0012_3456);
        rd(3'd2, 32'h0000_080A, "status_after_addr5");
        gen("irq_full", {63'b0, irq}, 64'd0);
        for (int k = 0; k < 8; k++) frame_q.push_back(exp_sd(pv[k]));
        base = frames_done;
        enable(32'd3);
        n = 0;
        while (irq !== 1'b1 && n < 5000) begin
            @(negedge clk);
            n++;
        end
        if (irq !== 1'b1) to_q.push_back("irq_rise");
        gen("frames_before_irq", 64'(frames_done - base), 64'd3);
        rd(3'd2, 32'h0000_0408, "status_fill4");
        wait_frames(base + 8, 8 * 1024 + 500, "drain_8");
        wr(3'd3, 32'd0);
        wr(3'd4, 32'd3);
        rd(3'd2, 32'h0000_0001, "status_drained");

        // Abort mid-frame, resume with the next pair
        push_pair(48'h111111_222222);
        push_pair(48'hC0FFEE_0BEEF0);
        enable(32'd1);
        n = 0;
        while (mon_idx != 40 && n < 1500) begin
            @(negedge clk);
            n++;
        end
        if (mon_idx != 40) to_q.push_back("reach_bit40");
        gen("ws_at_bit40", {63'b0, WS}, 64'd1);
        wr(3'd3, 32'd0);
        expect_pins("abort_idle", 4'b0000);
        frame_q.push_back(exp_sd(48'hC0FFEE_0BEEF0));
        base = frames_done;
        enable(32'd1);
        wait_frames(base + 1, 1500, "frame_after_abort");
        wr(3'd3, 32'd0);
        wr(3'd4, 32'd3);
        rd(3'd2, 32'h0000_0001, "status_after_abort");

`ifdef I2S_TX_MONO_EN
        wr(3'd5, 32'h0012_3456);
        frame_q.push_back(64'h091A2B00_091A2B00);
        base = frames_done;
        enable(32'd1);
        wait_frames(base + 1, 1500, "frame_mono");
        wr(3'd3, 32'd0);
        wr(3'd4, 32'd3);
`else
        wr(3'd5, 32'h0012_3456);
        rd(3'd2, 32'h0000_0001, "addr5_ignored");
`endif

        // Reset in the middle of a frame
        push_pair(48'h654321_123456);
        enable(32'd3);
        repeat (300) @(negedge clk);
        reset = 1'b1;
        repeat (2) @(negedge clk);
        expect_pins("reset_midframe_pins", 4'b0000);
        @(negedge clk);
        reset = 1'b0;
        rd(3'd2, 32'h0000_0001, "status_after_reset");
        rd(3'd3, 32'h0000_0000, "ctrl_after_reset");

        if (frame_q.size() != 0) to_q.push_back("frames_left_unchecked");
        repeat (3) @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
